// File: rtl/esp_dma64_responder.sv
// Memory-side responder for the 64-bit ESP DMA interface, backed by a word-addressed internal memory.
// Read beats start the cycle after accept and hold while ready is low; write beats sink one per cycle.
module esp_dma64_responder #(
  parameter int MEM_WORDS = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        dma_read_ctrl_valid,
  output logic        dma_read_ctrl_ready,
  input  logic [31:0] dma_read_ctrl_data_index,
  input  logic [31:0] dma_read_ctrl_data_length,
  input  logic [2:0]  dma_read_ctrl_data_size,
  output logic        dma_read_chnl_valid,
  input  logic        dma_read_chnl_ready,
  output logic [63:0] dma_read_chnl_data,
  input  logic        dma_write_ctrl_valid,
  output logic        dma_write_ctrl_ready,
  input  logic [31:0] dma_write_ctrl_data_index,
  input  logic [31:0] dma_write_ctrl_data_length,
  input  logic [2:0]  dma_write_ctrl_data_size,
  input  logic        dma_write_chnl_valid,
  output logic        dma_write_chnl_ready,
  input  logic [63:0] dma_write_chnl_data,
  output logic        busy,
  output logic        size_err,
  output logic [15:0] rd_done_cnt,
  output logic [15:0] wr_done_cnt
);

  localparam int AW = $clog2(MEM_WORDS);

  typedef enum logic [1:0] {IDLE, RD, WR} state_t;

  state_t        state;
  logic [AW-1:0] addr;
  logic [AW-1:0] next_addr;
  logic [31:0]   remaining;
  logic          prefer_wr;
  logic [63:0]   mem [MEM_WORDS];

  logic          idle;
  logic          both_req;
  logic          rd_acc;
  logic          wr_acc;
  logic          rd_hs;
  logic          wr_hs;
  logic [AW-1:0] rd_start;
  logic [AW-1:0] wr_start;

  // Index bits above the memory depth are deliberately discarded.
  logic unused_idx_bits;
  assign unused_idx_bits = ^{dma_read_ctrl_data_index[31:AW], dma_write_ctrl_data_index[31:AW]};

  assign idle      = (state == IDLE);
  assign busy      = !idle;
  assign both_req  = dma_read_ctrl_valid && dma_write_ctrl_valid;
  assign rd_start  = dma_read_ctrl_data_index[AW-1:0];
  assign wr_start  = dma_write_ctrl_data_index[AW-1:0];
  assign next_addr = addr + AW'(1);

  // Round-robin: under contention only the side not served last sees ready.
  assign dma_read_ctrl_ready  = idle && !(both_req && prefer_wr);
  assign dma_write_ctrl_ready = idle && !(both_req && !prefer_wr);

  assign rd_acc = dma_read_ctrl_valid && dma_read_ctrl_ready;
  assign wr_acc = dma_write_ctrl_valid && dma_write_ctrl_ready;
  assign rd_hs  = dma_read_chnl_valid && dma_read_chnl_ready;
  assign wr_hs  = dma_write_chnl_valid && dma_write_chnl_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state                <= IDLE;
      addr                 <= '0;
      remaining            <= '0;
      prefer_wr            <= 1'b0;
      dma_read_chnl_valid  <= 1'b0;
      dma_read_chnl_data   <= '0;
      dma_write_chnl_ready <= 1'b0;
      size_err             <= 1'b0;
      rd_done_cnt          <= '0;
      wr_done_cnt          <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (rd_acc) begin
            prefer_wr <= 1'b1;
            addr      <= rd_start;
            remaining <= dma_read_ctrl_data_length;
            if (dma_read_ctrl_data_size != 3'b011) size_err <= 1'b1;
            if (dma_read_ctrl_data_length == 32'd0) begin
              rd_done_cnt <= rd_done_cnt + 16'd1;
            end else begin
              state               <= RD;
              dma_read_chnl_valid <= 1'b1;
              dma_read_chnl_data  <= mem[rd_start];
            end
          end else if (wr_acc) begin
            prefer_wr <= 1'b0;
            addr      <= wr_start;
            remaining <= dma_write_ctrl_data_length;
            if (dma_write_ctrl_data_size != 3'b011) size_err <= 1'b1;
            if (dma_write_ctrl_data_length == 32'd0) begin
              wr_done_cnt <= wr_done_cnt + 16'd1;
            end else begin
              state                <= WR;
              dma_write_chnl_ready <= 1'b1;
            end
          end
        end
        RD: begin
          if (rd_hs) begin
            addr               <= next_addr;
            remaining          <= remaining - 32'd1;
            dma_read_chnl_data <= mem[next_addr];
            if (remaining == 32'd1) begin
              state               <= IDLE;
              dma_read_chnl_valid <= 1'b0;
              rd_done_cnt         <= rd_done_cnt + 16'd1;
            end
          end
        end
        WR: begin
          if (wr_hs) begin
            addr      <= next_addr;
            remaining <= remaining - 32'd1;
            if (remaining == 32'd1) begin
              state                <= IDLE;
              dma_write_chnl_ready <= 1'b0;
              wr_done_cnt          <= wr_done_cnt + 16'd1;
            end
          end
        end
        default: begin
          state                <= IDLE;
          dma_read_chnl_valid  <= 1'b0;
          dma_write_chnl_ready <= 1'b0;
        end
      endcase
    end
  end

  // Storage carries no reset so committed writes survive an aborted transaction.
  always_ff @(posedge clk) begin
    if (wr_hs) mem[addr] <= dma_write_chnl_data;
  end

endmodule

// File: tb/tb_esp_dma64_responder.sv
// Directed bench for esp_dma64_responder with a reference memory model and an expected-beat queue.
module tb_esp_dma64_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        rd_cv, rd_cr, wr_cv, wr_dv;
  logic [31:0] rd_idx, rd_len, wr_idx, wr_len;
  logic [2:0]  rd_sz, wr_sz;
  logic [63:0] wr_d;
  logic        dma_read_ctrl_ready, dma_write_ctrl_ready;
  logic        dma_read_chnl_valid, dma_write_chnl_ready;
  logic [63:0] dma_read_chnl_data;
  logic        busy, size_err;
  logic [15:0] rd_done_cnt, wr_done_cnt;

  always #5 clk = ~clk;

  esp_dma64_responder #(.MEM_WORDS(1024)) dut (
    .clk                        (clk),
    .rst                        (rst),
    .dma_read_ctrl_valid        (rd_cv),
    .dma_read_ctrl_ready        (dma_read_ctrl_ready),
    .dma_read_ctrl_data_index   (rd_idx),
    .dma_read_ctrl_data_length  (rd_len),
    .dma_read_ctrl_data_size    (rd_sz),
    .dma_read_chnl_valid        (dma_read_chnl_valid),
    .dma_read_chnl_ready        (rd_cr),
    .dma_read_chnl_data         (dma_read_chnl_data),
    .dma_write_ctrl_valid       (wr_cv),
    .dma_write_ctrl_ready       (dma_write_ctrl_ready),
    .dma_write_ctrl_data_index  (wr_idx),
    .dma_write_ctrl_data_length (wr_len),
    .dma_write_ctrl_data_size   (wr_sz),
    .dma_write_chnl_valid       (wr_dv),
    .dma_write_chnl_ready       (dma_write_chnl_ready),
    .dma_write_chnl_data        (wr_d),
    .busy                       (busy),
    .size_err                   (size_err),
    .rd_done_cnt                (rd_done_cnt),
    .wr_done_cnt                (wr_done_cnt)
  );

  int          checks = 0;
  int          errors = 0;
  logic [63:0] model [1024];
  logic [63:0] exp_q [$];
  logic [63:0] wq [$];
  logic [15:0] exp_rd, exp_wr;
  logic        exp_serr;
  logic        pref_rd;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; leaves the DUT out of reset at a later negedge.
  task automatic do_reset();
    rst = 1'b0;
    #1;
    chk("rst_rd_ctrl_ready", dma_read_ctrl_ready, 1'b1);
    chk("rst_wr_ctrl_ready", dma_write_ctrl_ready, 1'b1);
    chk("rst_rd_chnl_valid", dma_read_chnl_valid, 1'b0);
    chk("rst_wr_chnl_ready", dma_write_chnl_ready, 1'b0);
    chk("rst_rd_data", dma_read_chnl_data, 64'd0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_size_err", size_err, 1'b0);
    chk("rst_rd_cnt", rd_done_cnt, 16'd0);
    chk("rst_wr_cnt", wr_done_cnt, 16'd0);
    exp_rd = '0; exp_wr = '0; exp_serr = 1'b0; pref_rd = 1'b1;
    exp_q.delete();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic accept_rd(input int idx, input int len, input logic [2:0] sz);
    int t = 0;
    rd_cv = 1'b1; rd_idx = idx; rd_len = len; rd_sz = sz;
    #1;
    while (!dma_read_ctrl_ready && t < 20) begin @(negedge clk); #1; t++; end
    chk("rd_accept_ready", dma_read_ctrl_ready, 1'b1);
    for (int i = 0; i < len; i++) exp_q.push_back(model[(idx + i) % 1024]);
    if (sz != 3'b011) exp_serr = 1'b1;
    if (len == 0) exp_rd++;
    pref_rd = 1'b0;
    @(negedge clk);
    rd_cv = 1'b0;
    chk("rd_accept_size_err", size_err, exp_serr);
    if (len == 0) begin
      chk("zero_len_rd_cnt", rd_done_cnt, exp_rd);
      chk("zero_len_busy", busy, 1'b0);
      chk("zero_len_no_beat", dma_read_chnl_valid, 1'b0);
    end
  endtask

  task automatic accept_wr(input int idx, input int len, input logic [2:0] sz);
    int t = 0;
    wr_cv = 1'b1; wr_idx = idx; wr_len = len; wr_sz = sz;
    #1;
    while (!dma_write_ctrl_ready && t < 20) begin @(negedge clk); #1; t++; end
    chk("wr_accept_ready", dma_write_ctrl_ready, 1'b1);
    if (sz != 3'b011) exp_serr = 1'b1;
    if (len == 0) exp_wr++;
    pref_rd = 1'b1;
    @(negedge clk);
    wr_cv = 1'b0;
    chk("wr_accept_size_err", size_err, exp_serr);
  endtask

  // pat bit i drives read_chnl_ready in beat-phase cycle i; patlen 0 means always ready.
  task automatic rd_beats(input int len, input logic [15:0] pat, input int patlen);
    int          got = 0;
    int          cyc = 0;
    logic        held = 1'b0;
    logic [63:0] hd = '0;
    while (got < len && cyc < 200) begin
      if (held) chk("bp_hold_data", dma_read_chnl_data, hd);
      chk("rd_chnl_valid", dma_read_chnl_valid, 1'b1);
      rd_cr = (patlen == 0) ? 1'b1 : pat[cyc % patlen];
      if (rd_cr) begin
        chk("rd_data", dma_read_chnl_data,
            (exp_q.size() > 0) ? exp_q.pop_front() : 64'hBAD0_BAD0_BAD0_BAD0);
        got++;
        held = 1'b0;
      end else begin
        held = 1'b1;
        hd   = dma_read_chnl_data;
      end
      @(negedge clk);
      cyc++;
    end
    rd_cr = 1'b0;
    chk("rd_beat_count", 64'(got), 64'(len));
    exp_rd++;
    chk("rd_end_busy", busy, 1'b0);
    chk("rd_end_valid", dma_read_chnl_valid, 1'b0);
    chk("rd_done_cnt", rd_done_cnt, exp_rd);
  endtask

  task automatic wr_beats(input int idx, input int len);
    int got = 0;
    int cyc = 0;
    while (got < len && cyc < 200) begin
      wr_dv = 1'b1;
      wr_d  = wq[got];
      #1;
      chk("wr_chnl_ready", dma_write_chnl_ready, 1'b1);
      if (dma_write_chnl_ready) begin
        model[(idx + got) % 1024] = wr_d;
        got++;
      end
      @(negedge clk);
      cyc++;
    end
    wr_dv = 1'b0;
    chk("wr_beat_count", 64'(got), 64'(len));
    exp_wr++;
    chk("wr_end_busy", busy, 1'b0);
    chk("wr_end_ready", dma_write_chnl_ready, 1'b0);
    chk("wr_done_cnt", wr_done_cnt, exp_wr);
  endtask

  initial begin
    rst = 1'b0;
    rd_cv = 0; rd_cr = 0; wr_cv = 0; wr_dv = 0;
    rd_idx = 0; rd_len = 0; rd_sz = 3'b011;
    wr_idx = 0; wr_len = 0; wr_sz = 3'b011; wr_d = 0;
    @(negedge clk);
    do_reset();

    // Write then read back at index 4.
    wq = '{64'hA, 64'hB, 64'hC};
    accept_wr(4, 3, 3'b011);
    wr_beats(4, 3);
    accept_rd(4, 3, 3'b011);
    rd_beats(3, 16'h0, 0);
    chk("wr_then_rd_wr_cnt", wr_done_cnt, 16'd1);
    chk("wr_then_rd_rd_cnt", rd_done_cnt, 16'd1);

    // Back-pressure with ready pattern 1,0,0,1,1,0,1.
    wq = '{64'h11, 64'h22, 64'h33, 64'h44};
    accept_wr(20, 4, 3'b011);
    wr_beats(20, 4);
    accept_rd(20, 4, 3'b011);
    rd_beats(4, 16'b1011001, 7);

    // Address wrap at the top of memory.
    wq = '{64'd1, 64'd2, 64'd3, 64'd4};
    accept_wr(1022, 4, 3'b011);
    wr_beats(1022, 4);
    accept_rd(1022, 4, 3'b011);
    rd_beats(4, 16'h0, 0);
    accept_rd(0, 2, 3'b011);
    rd_beats(2, 16'h0, 0);

    // Zero-length read, then a write with an illegal size code.
    accept_rd(8, 0, 3'b011);
    @(negedge clk);
    chk("zero_len_still_no_beat", dma_read_chnl_valid, 1'b0);
    wq = '{64'h55};
    accept_wr(60, 1, 3'b010);
    wr_beats(60, 1);
    chk("size_err_set", size_err, 1'b1);
    accept_rd(60, 1, 3'b011);
    rd_beats(1, 16'h0, 0);
    chk("size_err_sticky", size_err, 1'b1);

    // Simultaneous requests from reset: expected order read, write, read.
    do_reset();
    for (int r = 0; r < 3; r++) begin
      rd_cv = 1'b1; rd_idx = 4; rd_len = 1; rd_sz = 3'b011;
      wr_cv = 1'b1; wr_idx = 70 + r; wr_len = 1; wr_sz = 3'b011;
      #1;
      chk("arb_rd_ready", dma_read_ctrl_ready, pref_rd);
      chk("arb_wr_ready", dma_write_ctrl_ready, !pref_rd);
      if (pref_rd) exp_q.push_back(model[4]);
      @(negedge clk);
      rd_cv = 1'b0; wr_cv = 1'b0;
      if (pref_rd) begin
        rd_beats(1, 16'h0, 0);
      end else begin
        wq.delete();
        wq.push_back(64'(100 + r));
        wr_beats(70 + r, 1);
      end
      pref_rd = !pref_rd;
    end
    chk("arb_rd_total", rd_done_cnt, 16'd2);
    chk("arb_wr_total", wr_done_cnt, 16'd1);

    // Reset asserted after two of eight read beats.
    wq.delete();
    for (int i = 0; i < 8; i++) wq.push_back(64'h1000 + 64'(i));
    accept_wr(100, 8, 3'b011);
    wr_beats(100, 8);
    accept_rd(100, 8, 3'b011);
    rd_cr = 1'b1;
    for (int i = 0; i < 2; i++) begin
      chk("mid_rd_data", dma_read_chnl_data, exp_q.pop_front());
      @(negedge clk);
    end
    rd_cr = 1'b0;
    chk("mid_rd_busy", busy, 1'b1);
    do_reset();
    accept_rd(100, 8, 3'b011);
    rd_beats(8, 16'h0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
